// File: rtl/fb_pixel_writer.sv
// Raster pixel stream to frame-buffer write port.
// Takes pixels over valid/ready, tracks the (h,v) cursor plus a running linear
// address, and issues one registered memory write per accepted pixel.
module fb_pixel_writer #(
   parameter int H_WIDTH   = 200,
   parameter int V_WIDTH   = 600,
   parameter int R_DEPTH   = 2,
   parameter int G_DEPTH   = 2,
   parameter int B_DEPTH   = 2,
   parameter int H_BITS    = 9,
   parameter int V_BITS    = 10,
   parameter int ADDR_BITS = 17,
   parameter int COLOR_BITS = R_DEPTH + G_DEPTH + B_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   input  logic [COLOR_BITS-1:0] pix_data,
   output logic                  pix_ready,
   input  logic                  wr_stall,
   output logic                  wr_en,
   output logic [ADDR_BITS-1:0]  wr_addr,
   output logic [COLOR_BITS-1:0] wr_data,
   output logic [H_BITS-1:0]     h_index,
   output logic [V_BITS-1:0]     v_index,
   output logic                  frame_done,
   output logic                  sof_err
);

   localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_WIDTH - 1);
   localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_WIDTH - 1);

   typedef enum logic {SYNC, ACTIVE} state_t;

   state_t                state, state_nxt;
   logic [H_BITS-1:0]     h_cnt, h_nxt;
   logic [V_BITS-1:0]     v_cnt, v_nxt;
   logic [ADDR_BITS-1:0]  addr_cnt, addr_nxt;
   logic                  wr_en_nxt, frame_done_nxt, sof_err_nxt;
   logic [ADDR_BITS-1:0]  wr_addr_nxt;
   logic [COLOR_BITS-1:0] wr_data_nxt;

   // Position the accepted pixel lands on: SOF always restarts at (0,0).
   logic [H_BITS-1:0]     base_h;
   logic [V_BITS-1:0]     base_v;
   logic [ADDR_BITS-1:0]  base_addr;
   logic                  accept;

   // Stall only gates acceptance; a write already registered still goes out.
   assign pix_ready = !rst && !wr_stall;
   assign accept    = pix_valid && pix_ready;
   assign base_h    = pix_sof ? '0 : h_cnt;
   assign base_v    = pix_sof ? '0 : v_cnt;
   assign base_addr = pix_sof ? '0 : addr_cnt;

   assign h_index = h_cnt;
   assign v_index = v_cnt;

   // Next-state, cursor advance and write-port values.
   always_comb begin
      state_nxt      = state;
      h_nxt          = h_cnt;
      v_nxt          = v_cnt;
      addr_nxt       = addr_cnt;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = wr_addr;
      wr_data_nxt    = wr_data;
      frame_done_nxt = 1'b0;
      sof_err_nxt    = 1'b0;
      // In SYNC only an SOF pixel is taken; everything else is dropped.
      if (accept && (pix_sof || state == ACTIVE)) begin
         wr_en_nxt   = 1'b1;
         wr_addr_nxt = base_addr;
         wr_data_nxt = pix_data;
         sof_err_nxt = pix_sof && (state == ACTIVE);
         if (base_h == H_LAST && base_v == V_LAST) begin
            // Last pixel of the frame: rewind and wait for the next SOF.
            frame_done_nxt = 1'b1;
            h_nxt          = '0;
            v_nxt          = '0;
            addr_nxt       = '0;
            state_nxt      = SYNC;
         end else begin
            state_nxt = ACTIVE;
            addr_nxt  = base_addr + 1'b1;
            if (base_h == H_LAST) begin
               h_nxt = '0;
               v_nxt = base_v + 1'b1;
            end else begin
               h_nxt = base_h + 1'b1;
               v_nxt = base_v;
            end
         end
      end
   end

   // State, cursor and registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SYNC;
         h_cnt      <= '0;
         v_cnt      <= '0;
         addr_cnt   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         h_cnt      <= h_nxt;
         v_cnt      <= v_nxt;
         addr_cnt   <= addr_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         frame_done <= frame_done_nxt;
         sof_err    <= sof_err_nxt;
      end
   end

endmodule
